// File: rtl/request_panel.sv
// request_panel
//
// Input conditioner in front of the elevator controller. Raw, asynchronous,
// bouncing cab / hall-up / hall-down buttons are synchronized and debounced
// per channel. Each accepted press becomes a single-cycle request pulse, and
// the button lamps are driven from the same events. The controller's
// current_floor / door_open feedback clears the lamps of the floor being
// served and suppresses presses for that floor while its door is open.
//
// Ports
//   clk             rising-edge clock
//   reset_n         synchronous active-low reset
//   btn_cab         raw cab buttons, bit f = floor f
//   btn_up          raw hall-up buttons (top-floor bit unused)
//   btn_down        raw hall-down buttons (floor-0 bit unused)
//   current_floor   car position from the controller
//   door_open       controller door-open flag
//   inside_request  one-cycle pulse per accepted cab press
//   call_up         one-cycle pulse per accepted up press
//   call_down       one-cycle pulse per accepted down press
//   lamp_cab/up/down  button lamps

// ---------------------------------------------------------------------------
// request_channel: one button -> synchronizer -> debounce FSM -> pulse + lamp
// ---------------------------------------------------------------------------
// Ports
//   clk, reset_n  clock and synchronous active-low reset
//   raw           asynchronous button level
//   serve         car is at this channel's floor with the door open
//   pulse         registered one-cycle accepted-press pulse
//   lamp          registered button lamp
module request_channel #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic serve,
    output logic pulse,
    output logic lamp
);

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        CHK_H = 2'd1,
        HIGH  = 2'd2,
        CHK_L = 2'd3
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             accept;

    // Debounce: a level change is taken only after the synchronized input
    // has held the new value for the full count; any dropout restarts it.
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        accept     = 1'b0;
        case (state)
            LOW: begin
                if (s2) next_state = CHK_H;
            end
            CHK_H: begin
                if (!s2) begin
                    next_state = LOW;
                end else if (cnt == CNT_LAST) begin
                    next_state = HIGH;
                    accept     = 1'b1;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!s2) next_state = CHK_L;
            end
            CHK_L: begin
                // Release is debounced the same way but never pulses.
                if (s2) begin
                    next_state = HIGH;
                end else if (cnt == CNT_LAST) begin
                    next_state = LOW;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                next_state = LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LOW;
            cnt   <= '0;
            pulse <= 1'b0;
            lamp  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= next_state;
            cnt   <= next_cnt;
            // A press at the floor already being served is swallowed.
            pulse <= accept && !serve;
            // Service clear wins over a new press at the same floor.
            if (serve)       lamp <= 1'b0;
            else if (accept) lamp <= 1'b1;
        end
    end

endmodule

// ---------------------------------------------------------------------------
// request_panel: FLOORS x {cab, up, down} channels
// ---------------------------------------------------------------------------
module request_panel #(
    parameter int FLOORS          = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FLOORS-1:0] btn_cab,
    input  logic [FLOORS-1:0] btn_up,
    input  logic [FLOORS-1:0] btn_down,
    input  logic [1:0]        current_floor,
    input  logic              door_open,
    output logic [FLOORS-1:0] inside_request,
    output logic [FLOORS-1:0] call_up,
    output logic [FLOORS-1:0] call_down,
    output logic [FLOORS-1:0] lamp_cab,
    output logic [FLOORS-1:0] lamp_up,
    output logic [FLOORS-1:0] lamp_down
);

    // No up call exists at the top floor and no down call at floor 0; those
    // raw inputs are intentionally dropped.
    logic unused_btn_bits;
    assign unused_btn_bits = btn_up[FLOORS-1] ^ btn_down[0];

    for (genvar f = 0; f < FLOORS; f++) begin : g_floor
        localparam logic [1:0] FLOOR_ID = 2'(f);

        logic serve;
        assign serve = door_open && (current_floor == FLOOR_ID);

        request_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cab (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (btn_cab[f]),
            .serve  (serve),
            .pulse  (inside_request[f]),
            .lamp   (lamp_cab[f])
        );

        if (f < FLOORS - 1) begin : g_up
            request_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_up (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (btn_up[f]),
                .serve  (serve),
                .pulse  (call_up[f]),
                .lamp   (lamp_up[f])
            );
        end else begin : g_up_none
            assign call_up[f] = 1'b0;
            assign lamp_up[f] = 1'b0;
        end

        if (f > 0) begin : g_down
            request_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_down (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (btn_down[f]),
                .serve  (serve),
                .pulse  (call_down[f]),
                .lamp   (lamp_down[f])
            );
        end else begin : g_down_none
            assign call_down[f] = 1'b0;
            assign lamp_down[f] = 1'b0;
        end
    end

endmodule

// File: tb/tb_request_panel.sv
// Directed bench for request_panel (FLOORS=4, DEBOUNCE_CYCLES=8).
module tb_request_panel;

    logic       clk;
    logic       reset_n;
    logic [3:0] btn_cab;
    logic [3:0] btn_up;
    logic [3:0] btn_down;
    logic [1:0] current_floor;
    logic       door_open;
    logic [3:0] inside_request;
    logic [3:0] call_up;
    logic [3:0] call_down;
    logic [3:0] lamp_cab;
    logic [3:0] lamp_up;
    logic [3:0] lamp_down;

    int n_chk  = 0;
    int n_pass = 0;

    request_panel #(
        .FLOORS         (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_cab       (btn_cab),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .current_floor (current_floor),
        .door_open     (door_open),
        .inside_request(inside_request),
        .call_up       (call_up),
        .call_down     (call_down),
        .lamp_cab      (lamp_cab),
        .lamp_up       (lamp_up),
        .lamp_down     (lamp_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges. Edge index 0 is the first edge after the call, i.e. the
    // first edge that samples freshly driven buttons. Reports the index of
    // the first pulse cycle, the pulse patterns there, and how many cycles
    // had any pulse.
    task automatic watch(input int n, output int first, output int npulse,
                         output logic [3:0] p_cab, output logic [3:0] p_up,
                         output logic [3:0] p_dn);
        first  = -1;
        npulse = 0;
        p_cab  = '0;
        p_up   = '0;
        p_dn   = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (|{inside_request, call_up, call_down}) begin
                if (first < 0) begin
                    first = i;
                    p_cab = inside_request;
                    p_up  = call_up;
                    p_dn  = call_down;
                end
                npulse++;
            end
        end
    endtask

    int         first;
    int         npulse;
    logic [3:0] p_cab;
    logic [3:0] p_up;
    logic [3:0] p_dn;

    initial begin
        // ---- reset with every button pressed ----
        reset_n       = 1'b0;
        btn_cab       = 4'hF;
        btn_up        = 4'hF;
        btn_down      = 4'hF;
        current_floor = 2'd3;
        door_open     = 1'b0;
        repeat (4) tick();
        check("rst_pulses", {20'd0, inside_request, call_up, call_down}, 32'd0);
        check("rst_lamps",  {20'd0, lamp_cab, lamp_up, lamp_down}, 32'd0);

        // ---- release reset, cab[2] held across release ----
        reset_n  = 1'b1;
        btn_cab  = 4'b0100;
        btn_up   = 4'b0000;
        btn_down = 4'b0000;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("first_latency", first, 10);
        check("first_count",   npulse, 1);
        check("first_pattern", p_cab, 4'b0100);
        check("first_lamp",    lamp_cab, 4'b0100);
        btn_cab = 4'b0000;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("cab_release_nopulse", npulse, 0);

        // ---- bounce on up[1]: 1,0,1,1,0 then hold ----
        btn_up[1] = 1'b1; tick();
        btn_up[1] = 1'b0; tick();
        btn_up[1] = 1'b1; tick();
        btn_up[1] = 1'b1; tick();
        btn_up[1] = 1'b0; tick();
        btn_up[1] = 1'b1;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("bounce_latency", first, 10);
        check("bounce_count",   npulse, 1);
        check("bounce_pattern", p_up, 4'b0010);
        btn_up[1] = 1'b0;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("bounce_release", npulse, 0);

        // ---- short glitch (7 cycles) never accepted ----
        btn_up[1] = 1'b1;
        repeat (7) tick();
        btn_up[1] = 1'b0;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("glitch_nopulse", npulse, 0);

        // ---- hold down[3] 50 cycles, release, press again ----
        btn_down[3] = 1'b1;
        watch(50, first, npulse, p_cab, p_up, p_dn);
        check("hold_count",   npulse, 1);
        check("hold_latency", first, 10);
        check("hold_pattern", p_dn, 4'b1000);
        btn_down[3] = 1'b0;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("hold_release", npulse, 0);
        btn_down[3] = 1'b1;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("repress_count",   npulse, 1);
        check("repress_latency", first, 10);
        btn_down[3] = 1'b0;
        watch(20, first, npulse, p_cab, p_up, p_dn);

        // ---- light cab[1] too, then service floor 1 ----
        btn_cab[1] = 1'b1;
        watch(15, first, npulse, p_cab, p_up, p_dn);
        btn_cab[1] = 1'b0;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("pre_serve_cab",  lamp_cab, 4'b0110);
        check("pre_serve_up",   lamp_up, 4'b0010);
        check("pre_serve_down", lamp_down, 4'b1000);
        current_floor = 2'd1;
        door_open     = 1'b1;
        tick();
        door_open     = 1'b0;
        check("serve_cab",  lamp_cab, 4'b0100);
        check("serve_up",   lamp_up, 4'b0000);
        check("serve_down", lamp_down, 4'b1000);

        // ---- suppression at floor 0 with door open; cab[3] still pulses ----
        current_floor = 2'd0;
        door_open     = 1'b1;
        btn_cab       = 4'b1001;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("supp_latency", first, 10);
        check("supp_count",   npulse, 1);
        check("supp_pattern", p_cab, 4'b1000);
        check("supp_lamp",    lamp_cab, 4'b1100);
        btn_cab = 4'b0000;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        door_open = 1'b0;

        // ---- invalid channels ----
        btn_up   = 4'b1000;
        btn_down = 4'b0001;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("invalid_nopulse", npulse, 0);
        check("invalid_lamp_up", lamp_up, 4'b0000);
        check("invalid_lamp_dn", lamp_down, 4'b1000);
        btn_up   = 4'b0000;
        btn_down = 4'b0000;
        watch(20, first, npulse, p_cab, p_up, p_dn);

        // ---- simultaneous presses on three channels ----
        btn_cab  = 4'b0001;
        btn_up   = 4'b0001;
        btn_down = 4'b0100;
        watch(20, first, npulse, p_cab, p_up, p_dn);
        check("simul_latency", first, 10);
        check("simul_count",   npulse, 1);
        check("simul_cab",     p_cab, 4'b0001);
        check("simul_up",      p_up, 4'b0001);
        check("simul_down",    p_dn, 4'b0100);
        check("simul_lamps",   {20'd0, lamp_cab, lamp_up, lamp_down}, {20'd0, 4'b1101, 4'b0001, 4'b1100});

        // ---- reset clears lamps ----
        reset_n = 1'b0;
        tick();
        check("reset2_lamps", {20'd0, lamp_cab, lamp_up, lamp_down}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
